// File: rtl/mor1kx_bp_update_ctrl.sv
// Update scheduler for the branch predictor pattern table: queues resolved branch
// outcomes, saturates their counters and writes them when decode leaves the port free.
module mor1kx_bp_update_ctrl #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int INDEX_WIDTH          = 6,
   parameter int COUNTER_WIDTH        = 2,
   parameter int QUEUE_DEPTH_LOG2     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     resolve_valid_i,
   input  logic [INDEX_WIDTH-1:0]   resolve_index_i,
   input  logic [COUNTER_WIDTH-1:0] resolve_counter_i,
   input  logic                     resolve_taken_i,
   input  logic                     predict_req_i,
   output logic                     predict_stall_o,
   output logic                     tbl_we_o,
   output logic [INDEX_WIDTH-1:0]   tbl_waddr_o,
   output logic [COUNTER_WIDTH-1:0] tbl_wdata_o,
   output logic                     init_busy_o,
   output logic                     queue_full_o,
   output logic                     overflow_o
);

   localparam int QUEUE_DEPTH = 1 << QUEUE_DEPTH_LOG2;
   localparam logic [COUNTER_WIDTH-1:0] WNT = COUNTER_WIDTH'((1 << (COUNTER_WIDTH-1)) - 1);
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
   localparam logic [QUEUE_DEPTH_LOG2:0] FULL_COUNT = (QUEUE_DEPTH_LOG2+1)'(QUEUE_DEPTH);

   // Operand width only matters to the predictors; an index wider than it is suspicious.
   if (OPTION_OPERAND_WIDTH < INDEX_WIDTH) begin : g_index_exceeds_operand
   end

   typedef enum logic {INIT, RUN} state_t;

   state_t                      state;
   logic [INDEX_WIDTH-1:0]      sweep_ptr;
   logic [QUEUE_DEPTH_LOG2-1:0] head;
   logic [QUEUE_DEPTH_LOG2-1:0] tail;
   logic [QUEUE_DEPTH_LOG2:0]   count;
   logic [QUEUE_DEPTH_LOG2:0]   count_next;
   logic [INDEX_WIDTH-1:0]      q_idx [QUEUE_DEPTH];
   logic [COUNTER_WIDTH-1:0]    q_val [QUEUE_DEPTH];
   logic                        stage_valid;
   logic [INDEX_WIDTH-1:0]      stage_idx;
   logic [COUNTER_WIDTH-1:0]    stage_val;
   logic                        in_run;
   logic                        q_full;
   logic                        q_empty;
   logic                        pop;
   logic                        push_req;
   logic                        push;
   logic                        drop;
   logic [COUNTER_WIDTH-1:0]    next_val;

   // A full queue overrides decode's claim on the port so updates cannot starve.
   always_comb begin
      in_run   = (state == RUN);
      q_full   = (count == FULL_COUNT);
      q_empty  = (count == '0);
      pop      = in_run & ~flush_i & ~q_empty & (~predict_req_i | q_full);
      push_req = in_run & ~flush_i & resolve_valid_i;
      push     = push_req & (~q_full | pop);
      drop     = push_req & ~push;

      next_val = resolve_counter_i;
      if (resolve_taken_i && (resolve_counter_i != '1))
         next_val = resolve_counter_i + COUNTER_WIDTH'(1);
      else if (!resolve_taken_i && (resolve_counter_i != '0))
         next_val = resolve_counter_i - COUNTER_WIDTH'(1);

      count_next = count;
      if (push && !pop)
         count_next = count + (QUEUE_DEPTH_LOG2+1)'(1);
      else if (pop && !push)
         count_next = count - (QUEUE_DEPTH_LOG2+1)'(1);
   end

   assign predict_stall_o = predict_req_i & q_full & in_run;

   always_ff @(posedge clk) begin
      if (push) begin
         q_idx[tail] <= resolve_index_i;
         q_val[tail] <= next_val;
      end
   end

   // Popped entries pass through a staging register before reaching the table port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= INIT;
         sweep_ptr    <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         stage_valid  <= 1'b0;
         stage_idx    <= '0;
         stage_val    <= '0;
         tbl_we_o     <= 1'b0;
         tbl_waddr_o  <= '0;
         tbl_wdata_o  <= '0;
         init_busy_o  <= 1'b1;
         queue_full_o <= 1'b0;
         overflow_o   <= 1'b0;
      end else if (flush_i) begin
         state        <= INIT;
         sweep_ptr    <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         stage_valid  <= 1'b0;
         tbl_we_o     <= 1'b0;
         init_busy_o  <= 1'b1;
         queue_full_o <= 1'b0;
         overflow_o   <= 1'b0;
      end else if (state == INIT) begin
         tbl_we_o    <= 1'b1;
         tbl_waddr_o <= sweep_ptr;
         tbl_wdata_o <= WNT;
         sweep_ptr   <= sweep_ptr + INDEX_WIDTH'(1);
         overflow_o  <= 1'b0;
         if (sweep_ptr == LAST_INDEX)
            state <= RUN;
      end else begin
         init_busy_o <= 1'b0;
         tbl_we_o    <= stage_valid;
         if (stage_valid) begin
            tbl_waddr_o <= stage_idx;
            tbl_wdata_o <= stage_val;
         end
         stage_valid <= pop;
         if (pop) begin
            stage_idx <= q_idx[head];
            stage_val <= q_val[head];
            head      <= head + QUEUE_DEPTH_LOG2'(1);
         end
         if (push)
            tail <= tail + QUEUE_DEPTH_LOG2'(1);
         count        <= count_next;
         queue_full_o <= (count_next == FULL_COUNT);
         overflow_o   <= drop;
      end
   end

endmodule
